// File: rtl/pio_cmd_pkg.sv
// -----------------------------------------------------------------------------
// pio_cmd_pkg
// Shared definitions for the PIO command queue. It holds the following:
//   - state_t     : FSM encoding (ST_INIT = 1'b0, ST_RUN = 1'b1)
//   - TOGGLE_BIT  : bit of the PIO word that software flips for each new command
//   - ST_*        : bit positions inside status_word
//   - CNT_W       : width of the optional drop counter
//                   (the counter exists only when PIO_CMD_OVF_CNT_EN is defined)
// -----------------------------------------------------------------------------
package pio_cmd_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int TOGGLE_BIT = 31;

  localparam int ST_OVF     = 31;
  localparam int ST_FULL    = 30;
  localparam int ST_EMPTY   = 29;
  localparam int ST_CNT_LSB = 16;

  localparam int CNT_W      = 8;

endpackage

// File: rtl/pio_cmd_fifo.sv
// -----------------------------------------------------------------------------
// pio_cmd_fifo
// DEPTH x DW synchronous first-word-fall-through FIFO with a registered head.
// The head entry is held in its own register, so dout never glitches.
// dout changes only on an accepted pop, or when the FIFO goes from empty to
// non-empty.
//
// Ports
//   clk, reset_n : clock, asynchronous active-low reset
//   push, din    : write request and write data
//   pop          : retire head (ignored while empty)
//   dout, valid  : registered head entry and its valid flag
//   level        : occupancy 0..DEPTH (AW+1 bits)
//   full, empty  : derived from level
// -----------------------------------------------------------------------------
module pio_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 31
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_cnt;
  logic [AW:0]   rd_cnt;
  logic [DW-1:0] head_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign level      = wr_cnt - rd_cnt;
  assign full       = (level == (AW+1)'(DEPTH));
  assign empty      = (level == '0);
  assign wr_ptr     = wr_cnt[AW-1:0];
  assign rd_nxt_ptr = rd_cnt[AW-1:0] + 1'b1;

  // A pop on a full FIFO frees a slot in the same cycle, so that push is kept.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign dout  = head_q;
  assign valid = ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      head_q <= '0;
    end else begin
      if (push_ok) wr_cnt <= wr_cnt + 1'b1;
      if (pop_ok)  rd_cnt <= rd_cnt + 1'b1;
      // The head register is refreshed in one of two cases.
      // Case 1: empty to non-empty. The head takes the incoming word.
      // Case 2: a pop. The head takes the next stored entry. If only one
      //   entry was stored, it takes the word being pushed in this cycle.
      if (empty && push_ok) begin
        head_q <= din;
      end else if (pop_ok) begin
        if (level == (AW+1)'(1)) begin
          if (push_ok) head_q <= din;
        end else begin
          head_q <= mem[rd_nxt_ptr];
        end
      end
    end
  end

endmodule

// File: rtl/pio_cmd_queue.sv
// -----------------------------------------------------------------------------
// pio_cmd_queue
// Consumer stage on a 32-bit Avalon PIO out_port that has no write strobe.
// Software flips pio_in[31] (TOGGLE) for each new command. Every toggle edge
// queues pio_in[30:0]. Queued payloads go to the command engine over
// valid/ready. A status word is exported for an input PIO.
//
// Ports
//   clk, reset_n   : clock, asynchronous active-low reset
//   pio_in[31:0]   : PIO word; [31] = TOGGLE, [30:0] = payload
//   cmd_ready      : engine accepts the head entry
//   ovf_clr        : one-cycle pulse that clears the sticky overflow flag
//                    (and the drop counter when that counter exists)
//   cmd_valid      : head entry valid
//   cmd_data       : head payload, registered
//   fifo_level     : occupancy 0..DEPTH
//   status_word    : {overflow, full, empty, 5'b0, drop_cnt[7:0], 11'b0, level}
//
// Build option: define PIO_CMD_OVF_CNT_EN to add an 8-bit saturating drop
// counter in status_word[23:16]. Without it, that field reads 0.
// -----------------------------------------------------------------------------
module pio_cmd_queue
  import pio_cmd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 31
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   pio_in,
  input  logic          cmd_ready,
  input  logic          ovf_clr,
  output logic          cmd_valid,
  output logic [DW-1:0] cmd_data,
  output logic [AW:0]   fifo_level,
  output logic [31:0]   status_word
);

  state_t           state;
  logic             tog_q;
  logic             push_req;
  logic             full;
  logic             empty;
  logic             drop;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;

  // INIT only samples the toggle. This keeps the PIO reset value, or a toggle
  // already high at reset release, from being taken as a command.
  assign push_req = (state == ST_RUN) && (pio_in[TOGGLE_BIT] != tog_q);
  assign drop     = push_req & full & ~cmd_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
      tog_q <= 1'b0;
    end else begin
      tog_q <= pio_in[TOGGLE_BIT];
      case (state)
        ST_INIT: state <= ST_RUN;
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_INIT;
      endcase
    end
  end

  pio_cmd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .din     (pio_in[DW-1:0]),
    .pop     (cmd_ready),
    .dout    (cmd_data),
    .valid   (cmd_valid),
    .level   (fifo_level),
    .full    (full),
    .empty   (empty)
  );

  // A new drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef PIO_CMD_OVF_CNT_EN
  // Saturating counter. A clear that coincides with a drop leaves a count of 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      drop_cnt <= drop ? CNT_W'(1) : '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

  always_comb begin
    status_word                         = '0;
    status_word[ST_OVF]                 = overflow;
    status_word[ST_FULL]                = full;
    status_word[ST_EMPTY]               = empty;
    status_word[ST_CNT_LSB +: CNT_W]    = drop_cnt;
    status_word[AW:0]                   = fifo_level;
  end

endmodule

// File: tb/tb_pio_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_pio_cmd_queue
// Directed bench for pio_cmd_queue. A reference queue holds the expected
// payloads together with the toggle, overflow and counter state. After every
// clock the DUT outputs are compared against that model.
// -----------------------------------------------------------------------------
module tb_pio_cmd_queue;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 31;
`ifdef PIO_CMD_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   pio_in;
  logic          cmd_ready;
  logic          ovf_clr;
  logic          cmd_valid;
  logic [DW-1:0] cmd_data;
  logic [AW:0]   fifo_level;
  logic [31:0]   status_word;

  pio_cmd_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pio_in      (pio_in),
    .cmd_ready   (cmd_ready),
    .ovf_clr     (ovf_clr),
    .cmd_valid   (cmd_valid),
    .cmd_data    (cmd_data),
    .fifo_level  (fifo_level),
    .status_word (status_word)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  bit            run_m = 0;
  bit            tog_m = 0;
  bit            ovf_m = 0;
  int            cnt_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s        = '0;
    s[31]    = ovf_m;
    s[30]    = (q.size() == DEPTH);
    s[29]    = (q.size() == 0);
    s[23:16] = CNT_EN ? 8'(cnt_m) : 8'h00;
    s[4:0]   = 5'(q.size());
    return s;
  endfunction

  task automatic post_check(input string tag);
    chk({tag, "_valid"},  32'(cmd_valid),  32'(q.size() != 0));
    chk({tag, "_level"},  32'(fifo_level), 32'(q.size()));
    chk({tag, "_status"}, status_word,     exp_status());
    if (q.size() != 0) chk({tag, "_data"}, 32'(cmd_data), 32'(q[0]));
  endtask

  // Advance the model using the inputs currently driven, clock once, compare.
  task automatic cyc(input string tag);
    bit push, pop, drop;
    push = run_m && (pio_in[31] != tog_m);
    pop  = cmd_ready && (q.size() != 0);
    drop = 0;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(pio_in[DW-1:0]);
      else                  drop = 1;
    end
    if (drop)         ovf_m = 1;
    else if (ovf_clr) ovf_m = 0;
    if (ovf_clr)                  cnt_m = drop ? 1 : 0;
    else if (drop && cnt_m < 255) cnt_m++;
    tog_m = pio_in[31];
    run_m = 1;
    @(posedge clk);
    #1;
    post_check(tag);
  endtask

  task automatic send(input string tag, input logic [30:0] payload);
    pio_in = {~pio_in[31], payload};
    cyc(tag);
  endtask

  initial begin
    // 1: reset with the PIO reset value, then idle
    reset_n   = 1'b0;
    pio_in    = 32'h6190_0000;
    cmd_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(cmd_data), 32'h0);
    post_check("rst");
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc("t1_idle");
    chk("t1_level", 32'(fifo_level), 32'd0);

    // 2: two commands, then drain
    pio_in = 32'h8000_0005;
    cyc("t2_push1");
    chk("t2_data1", 32'(cmd_data), 32'h5);
    chk("t2_lvl1",  32'(fifo_level), 32'd1);
    pio_in = 32'h0000_000A;
    cyc("t2_push2");
    chk("t2_lvl2",  32'(fifo_level), 32'd2);
    chk("t2_hold",  32'(cmd_data), 32'h5);
    cmd_ready = 1'b1;
    cyc("t2_pop1");
    chk("t2_data2", 32'(cmd_data), 32'hA);
    cyc("t2_pop2");
    chk("t2_lvl0",  32'(fifo_level), 32'd0);
    cmd_ready = 1'b1;
    cyc("t2_rdy_empty");

    // 3: 17 commands with no consumer -> full, overflow, 17th dropped
    cmd_ready = 1'b0;
    for (int i = 1; i <= 17; i++) send("t3_fill", 31'(32'h100 + i));
    chk("t3_full", 32'(status_word[30]), 32'd1);
    chk("t3_ovf",  32'(status_word[31]), 32'd1);
    ovf_clr = 1'b1;
    cyc("t3_clr");
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", 32'(status_word[31]), 32'd0);

    // 4: push and pop together on a full FIFO
    cmd_ready = 1'b1;
    send("t4_pushpop", 31'h0055_AA77);
    chk("t4_lvl", 32'(fifo_level), 32'd16);
    chk("t4_ovf", 32'(status_word[31]), 32'd0);
    for (int i = 0; i < 9; i++) cyc("t4_drain");
    cmd_ready = 1'b0;
    cyc("t4_hold");
    chk("t4_lvl7", 32'(fifo_level), 32'd7);

    // 5: reset mid-operation with the toggle held high through release
    #2;
    reset_n = 1'b0;
    pio_in  = 32'h8000_0123;
    q.delete();
    run_m = 0; tog_m = 0; ovf_m = 0; cnt_m = 0;
    repeat (2) @(posedge clk);
    #1;
    post_check("t5_rst");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc("t5_idle");
    chk("t5_lvl0", 32'(fifo_level), 32'd0);
    pio_in = 32'h0000_0456;
    cyc("t5_push");
    cyc("t5_after");
    chk("t5_lvl1", 32'(fifo_level), 32'd1);
    cmd_ready = 1'b1;
    cyc("t5_drain");
    cmd_ready = 1'b0;

    // 6: drop counter saturation and clear colliding with a drop
    for (int i = 0; i < DEPTH + 300; i++) send("t6_fill", 31'(i));
    chk("t6_cnt", 32'(status_word[23:16]), CNT_EN ? 32'hFF : 32'h0);
    ovf_clr = 1'b1;
    send("t6_clr_drop", 31'h7FFF_FFFF);
    ovf_clr = 1'b0;
    chk("t6_cnt1", 32'(status_word[23:16]), CNT_EN ? 32'h1 : 32'h0);
    chk("t6_ovf1", 32'(status_word[31]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
